// File: rtl/stb_req_responder.sv
// Responder side of the stb_req/stb_valid strobe handshake: measures the reference
// period, fires one strobe at a clamped coarse offset after a reference edge, and reports done/timeout.
module stb_req_responder #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1 << 20,
  parameter int STB_W   = 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             sig_i,
  input  logic [CNT_W-1:0] coarse_dly_i,
  input  logic             stb_req_i,
  output logic             stb_valid_o,
  output logic             stb_o,
  output logic [CNT_W-1:0] period_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT1  = 3'd1;
  localparam logic [2:0] S_MEAS   = 3'd2;
  localparam logic [2:0] S_DELAY  = 3'd3;
  localparam logic [2:0] S_STROBE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STBW_C = CNT_W'(STB_W);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic             sync1_q, sync2_q, sync3_q, rise_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             stb_q, stb_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] eff;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  // Saturating increment; the timeout test uses the incremented value so ERR lands TIMEOUT cycles after accept.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE_C;
  assign eff     = (dly_q >= period_q) ? period_q - ONE_C : dly_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    period_d = period_q;
    stb_d    = stb_q;
    valid_d  = valid_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (stb_req_i && !valid_q) begin
          dly_d   = coarse_dly_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_WAIT1;
        end
      end
      S_WAIT1, S_MEAS: begin
        if (!stb_req_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
        end else if (rise_q) begin
          if (state_q == S_MEAS) begin
            period_d = cnt_q;
            cnt_d    = '0;
            state_d  = S_DELAY;
          end else begin
            cnt_d   = ONE_C;
            state_d = S_MEAS;
          end
        end else if (cnt_inc >= TO_C) begin
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DELAY: begin
        if (!stb_req_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == eff) begin
          stb_d   = 1'b1;
          cnt_d   = ONE_C;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STROBE: begin
        if (!stb_req_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q >= STBW_C) begin
          stb_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE, S_ERR: begin
        if (!stb_req_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        stb_d   = 1'b0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dly_q    <= '0;
      period_q <= '0;
      stb_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      period_q <= period_d;
      stb_q    <= stb_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign stb_valid_o = valid_q;
  assign stb_o       = stb_q;
  assign period_o    = period_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_stb_req_responder.sv
// Randomized self-checking bench for stb_req_responder: a cycle-numbered event model
// predicts period, strobe placement, completion cycle and timeout from recorded sig_i pulses.
module tb_stb_req_responder;
  localparam int CW = 32;
  localparam int TO = 64;
  localparam int SW = 1;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          sig_i = 1'b0;
  logic [CW-1:0] coarse_dly_i;
  logic          stb_req_i;
  logic          stb_valid_o, stb_o, err_o, busy_o;
  logic [CW-1:0] period_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edges[$];
  logic sig_prev = 1'b0;
  int gen_period = 0;
  int gen_base = 0;
  int stb_total = 0, stb_rise = -1, valid_rise = -1;
  logic stb_prev = 1'b0, valid_prev = 1'b0;
  int model_period = 0;

  stb_req_responder #(.CNT_W(CW), .TIMEOUT(TO), .STB_W(SW)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .sig_i(sig_i), .coarse_dly_i(coarse_dly_i),
    .stb_req_i(stb_req_i), .stb_valid_o(stb_valid_o), .stb_o(stb_o),
    .period_o(period_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Posedge numbering; record the edge at which each sig_i rise is first sampled.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (sig_i && !sig_prev) edges.push_back(cyc);
    sig_prev = sig_i;
  end

  // Reference pulse generator and output monitor, both away from the active edge.
  always @(negedge clk_i) begin
    sig_i = (gen_period > 0) && (cyc >= gen_base) && (((cyc - gen_base) % gen_period) == 0);
    if (stb_o === 1'b1) begin
      stb_total = stb_total + 1;
      if (!stb_prev) stb_rise = cyc;
    end
    stb_prev = (stb_o === 1'b1);
    if (stb_valid_o === 1'b1 && !valid_prev) valid_rise = cyc;
    valid_prev = (stb_valid_o === 1'b1);
  end

  // A rise sampled at edge k is acted on by the FSM at edge k+3; only edges after accept count.
  function automatic void find_rises(input int a, output int d1, output int d2);
    d1 = -1;
    d2 = -1;
    foreach (edges[i]) begin
      if (edges[i] + 3 > a) begin
        if (d1 < 0) d1 = edges[i] + 3;
        else if (d2 < 0) d2 = edges[i] + 3;
      end
    end
  endfunction

  function automatic void model(input int a, input logic [CW-1:0] dly, output int e_err,
                                output int e_period, output int e_stb, output int e_valid);
    int d1, d2, p, eff;
    find_rises(a, d1, d2);
    e_err = 1;
    e_period = model_period;
    e_stb = -1;
    if (d1 < 0 || d1 > a + TO) e_valid = a + TO;
    else if (d2 < 0 || d2 - d1 > TO - 1) e_valid = d1 + TO - 1;
    else begin
      p = d2 - d1;
      eff = (int'(dly) >= p) ? p - 1 : int'(dly);
      e_err = 0;
      e_period = p;
      e_stb = d2 + 1 + eff;
      e_valid = e_stb + SW;
    end
  endfunction

  task automatic start_gen(input int p, input int gap);
    gen_period = p;
    gen_base = cyc + gap;
  endtask

  task automatic run_req(input string name, input logic [CW-1:0] dly, input int next_period);
    int a, e_err, e_period, e_stb, e_valid, base, obs_stb;
    bit got;
    @(negedge clk_i); #1;
    base = stb_total;
    coarse_dly_i = dly;
    stb_req_i = 1'b1;
    a = cyc + 1;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk_i); #1;
      if (stb_valid_o === 1'b1) got = 1;
    end
    if (next_period > 0) start_gen(next_period, next_period);
    model(a, dly, e_err, e_period, e_stb, e_valid);
    obs_stb = (stb_total > base) ? stb_rise : -1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s valid_wait: stb_valid_o=%b after 300 cycles, required 1", name, stb_valid_o);
    end
    checks++;
    if (valid_rise !== e_valid) begin
      errors++;
      $display("FAIL %s valid_cycle: got %0d expected %0d", name, valid_rise, e_valid);
    end
    checks++;
    if (err_o !== (e_err != 0)) begin
      errors++;
      $display("FAIL %s err_o: got %b expected %0d", name, err_o, e_err);
    end
    checks++;
    if (period_o !== CW'(e_period)) begin
      errors++;
      $display("FAIL %s period_o: got %0d expected %0d", name, period_o, e_period);
    end
    checks++;
    if (obs_stb !== e_stb) begin
      errors++;
      $display("FAIL %s stb_cycle: got %0d expected %0d", name, obs_stb, e_stb);
    end
    checks++;
    if (stb_total - base !== ((e_err != 0) ? 0 : SW)) begin
      errors++;
      $display("FAIL %s stb_width: got %0d expected %0d", name, stb_total - base, (e_err != 0) ? 0 : SW);
    end
    if (e_err == 0) model_period = e_period;
    stb_req_i = 1'b0;
    @(negedge clk_i); #1;
    checks++;
    if (stb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s release: valid=%b busy=%b expected 0 0", name, stb_valid_o, busy_o);
    end
  endtask

  task automatic test_reset;
    arstn_i = 1'b0;
    stb_req_i = 1'b0;
    coarse_dly_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    checks++;
    if ({stb_valid_o, stb_o, err_o, busy_o} !== 4'b0 || period_o !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b stb=%b err=%b busy=%b period=%0d expected all 0",
               stb_valid_o, stb_o, err_o, busy_o, period_o);
    end
    arstn_i = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0 || stb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", busy_o, stb_valid_o);
    end
  endtask

  task automatic test_basic;
    start_gen(20, $urandom_range(2, 20));
    repeat (10) @(negedge clk_i);
    run_req("basic", 5, 0);
    checks++;
    if (period_o !== 20) begin
      errors++;
      $display("FAIL basic_period: got %0d expected 20", period_o);
    end
  endtask

  task automatic test_timeout;
    gen_period = 0;
    repeat (8) @(negedge clk_i);
    run_req("timeout", 7, 0);
    checks++;
    if (period_o !== 20) begin
      errors++;
      $display("FAIL timeout_period_kept: got %0d expected 20", period_o);
    end
  endtask

  task automatic test_clamp;
    start_gen(20, $urandom_range(2, 20));
    repeat (30) @(negedge clk_i);
    run_req("clamp", 30, 0);
    run_req("dly0", 0, 0);
  endtask

  task automatic test_abort;
    int a, d1, d2, base;
    bit dropped;
    @(negedge clk_i); #1;
    base = stb_total;
    coarse_dly_i = 15;
    stb_req_i = 1'b1;
    a = cyc + 1;
    dropped = 0;
    for (int i = 0; i < 200 && !dropped; i++) begin
      @(negedge clk_i); #1;
      find_rises(a, d1, d2);
      if (d2 > 0 && cyc >= d2 + 3) begin
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL abort_busy_before: got %b expected 1", busy_o);
        end
        stb_req_i = 1'b0;
        dropped = 1;
      end
    end
    stb_req_i = 1'b0;
    checks++;
    if (!dropped) begin
      errors++;
      $display("FAIL abort_reach_delay: measuring edge not seen within 200 cycles");
    end
    @(negedge clk_i); #1;
    checks++;
    if (busy_o !== 1'b0 || stb_valid_o !== 1'b0 || stb_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b valid=%b stb=%b expected 0 0 0", busy_o, stb_valid_o, stb_o);
    end
    repeat (30) @(negedge clk_i);
    #1;
    checks++;
    if (stb_total !== base || err_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_strobe: strobes=%0d err=%b expected 0 0", stb_total - base, err_o);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit seen;
    @(negedge clk_i); #1;
    coarse_dly_i = 3;
    stb_req_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i); #1;
      if (stb_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_strobe_wait: stb_o=%b after 200 cycles, required 1", stb_o);
    end
    #2 arstn_i = 1'b0;
    #1;
    checks++;
    if ({stb_o, busy_o, stb_valid_o, err_o} !== 4'b0 || period_o !== '0) begin
      errors++;
      $display("FAIL rstmid_async_clear: stb=%b busy=%b valid=%b err=%b period=%0d expected all 0",
               stb_o, busy_o, stb_valid_o, err_o, period_o);
    end
    stb_req_i = 1'b0;
    model_period = 0;
    @(negedge clk_i); #1;
    arstn_i = 1'b1;
    base = stb_total;
    repeat (40) @(negedge clk_i);
    #1;
    checks++;
    if (stb_total !== base || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: strobes=%0d busy=%b expected 0 0", stb_total - base, busy_o);
    end
  endtask

  task automatic test_back_to_back;
    start_gen(20, $urandom_range(2, 20));
    repeat (30) @(negedge clk_i);
    run_req("b2b_first", $urandom_range(0, 10), 12);
    run_req("b2b_second", $urandom_range(0, 10), 0);
    checks++;
    if (period_o !== 12) begin
      errors++;
      $display("FAIL b2b_period: got %0d expected 12", period_o);
    end
  endtask

  task automatic test_random;
    int p;
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(6, 30);
      start_gen(p, $urandom_range(2, p));
      repeat ($urandom_range(0, 40)) @(negedge clk_i);
      run_req("random", $urandom_range(0, 35), 0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_timeout;
    test_clamp;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
